game_controller: RTL

Sequencing controller for the tic-tac-toe board: owns the 9-cell board state and drives the `CONTROL_ARRAY` bus that `VGA_Controller` renders. It takes debounced button pulses and moves a cursor. It places X/O marks with alternating turns, then scans the eight winning lines over successive cycles to detect a win or a draw. It sits between the button front-end and `VGA_Controller`, on the same pixel clock.

---
 rtl/game_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/game_controller.sv
// game_controller: tic-tac-toe board sequencer with cursor, alternating turns and multi-cycle win/draw scan
module game_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BTN_LEFT,
    input  logic        BTN_RIGHT,
    input  logic        BTN_UP,
    input  logic        BTN_DOWN,
    input  logic        BTN_SELECT,
    input  logic        BTN_NEW,
    output logic [35:0] CONTROL_ARRAY,
    output logic        TURN,
    output logic        GAME_OVER,
    output logic [1:0]  WINNER
);
    typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;
    state_t      state, state_n;
    logic [1:0]  marks [9];
    logic [1:0]  marks_n [9];
    logic [3:0]  cursor, cursor_n, moves, moves_n;
    logic [2:0]  line, line_n;
    logic        turn_n;
    logic [1:0]  winner_n, ma;
    logic [8:0]  win_mask, win_mask_n;
    logic [3:0]  la, lb, lc;
    logic        hit, col0, col2;
    logic [35:0] ctrl_n;

    always_comb begin
        {la, lb, lc} = {4'd0, 4'd1, 4'd2};
        case (line)
            3'd1: {la, lb, lc} = {4'd3, 4'd4, 4'd5};
            3'd2: {la, lb, lc} = {4'd6, 4'd7, 4'd8};
            3'd3: {la, lb, lc} = {4'd0, 4'd3, 4'd6};
            3'd4: {la, lb, lc} = {4'd1, 4'd4, 4'd7};
            3'd5: {la, lb, lc} = {4'd2, 4'd5, 4'd8};
            3'd6: {la, lb, lc} = {4'd0, 4'd4, 4'd8};
            3'd7: {la, lb, lc} = {4'd2, 4'd4, 4'd6};
            default: ;
        endcase
    end

    assign ma   = marks[la];
    assign hit  = ma != 2'd0 && ma == marks[lb] && ma == marks[lc];
    assign col0 = cursor == 4'd0 || cursor == 4'd3 || cursor == 4'd6;
    assign col2 = cursor == 4'd2 || cursor == 4'd5 || cursor == 4'd8;
    assign GAME_OVER = state == WIN || state == DRAW;

    always_comb begin
        state_n    = state;
        marks_n    = marks;
        cursor_n   = cursor;
        moves_n    = moves;
        line_n     = line;
        turn_n     = TURN;
        winner_n   = WINNER;
        win_mask_n = win_mask;
        if (BTN_NEW) begin
            state_n    = PLAY;
            marks_n    = '{default: 2'd0};
            cursor_n   = 4'd4;
            moves_n    = 4'd0;
            line_n     = 3'd0;
            turn_n     = 1'b0;
            winner_n   = 2'd0;
            win_mask_n = 9'd0;
        end else begin
            case (state)
                PLAY: begin
                    // SELECT consumes the cycle even when the cell is occupied
                    if (BTN_SELECT) begin
                        if (marks[cursor] == 2'd0) begin
                            marks_n[cursor] = TURN ? 2'd2 : 2'd1;
                            moves_n = moves + 4'd1;
                            line_n  = 3'd0;
                            state_n = CHECK;
                        end
                    end else if (BTN_LEFT)  cursor_n = col0 ? cursor + 4'd2 : cursor - 4'd1;
                    else if (BTN_RIGHT)     cursor_n = col2 ? cursor - 4'd2 : cursor + 4'd1;
                    else if (BTN_UP)        cursor_n = cursor < 4'd3 ? cursor + 4'd6 : cursor - 4'd3;
                    else if (BTN_DOWN)      cursor_n = cursor > 4'd5 ? cursor - 4'd6 : cursor + 4'd3;
                end
                CHECK: begin
                    if (hit) begin
                        win_mask_n = (9'd1 << la) | (9'd1 << lb) | (9'd1 << lc);
                        winner_n   = ma;
                        state_n    = WIN;
                    end else if (line == 3'd7) begin
                        state_n = moves == 4'd9 ? DRAW : PLAY;
                        turn_n  = moves == 4'd9 ? TURN : ~TURN;
                    end else begin
                        line_n = line + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Display word is built from next-state values so it updates on the same edge
    always_comb begin
        ctrl_n = '0;
        for (int i = 0; i < 9; i++)
            ctrl_n[i*4 +: 4] = {win_mask_n[i], state_n == PLAY && cursor_n == 4'(i), marks_n[i]};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= PLAY;
            marks         <= '{default: 2'd0};
            cursor        <= 4'd4;
            moves         <= 4'd0;
            line          <= 3'd0;
            TURN          <= 1'b0;
            WINNER        <= 2'd0;
            win_mask      <= 9'd0;
            CONTROL_ARRAY <= 36'h000040000;
        end else begin
            state         <= state_n;
            marks         <= marks_n;
            cursor        <= cursor_n;
            moves         <= moves_n;
            line          <= line_n;
            TURN          <= turn_n;
            WINNER        <= winner_n;
            win_mask      <= win_mask_n;
            CONTROL_ARRAY <= ctrl_n;
        end
    end
endmodule
